// File: rtl/mem_wait_ctrl_pkg.sv
// Shared definitions for the wait-state memory controller: FSM encoding,
// parameter defaults and the wait-counter load helper.
package mem_wait_ctrl_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Wait counter width; supports 0..15 wait states
  localparam int CNT_W = 4;

  // Parameter defaults
  localparam int   DEF_WIDTH     = 8;
  localparam int   DEF_ADRBITS   = 8;
  localparam int   DEF_WAITS     = 1;
  // The I/O address defaults to all ones at whatever WIDTH is chosen
  localparam logic DEF_IOADR_BIT = 1'b1;

  // Value loaded into the wait counter when an access is accepted
  function automatic logic [CNT_W-1:0] wait_load(input int waits);
    if (waits > 0) begin
      return CNT_W'(waits - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/mem_wait_ctrl_ram.sv
// Single-port RAM for the controller: synchronous write, registered read.
// The read register refreshes every cycle from the current address.
module wait_ram
  import mem_wait_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADRBITS = DEF_ADRBITS
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADRBITS-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [0:(2**ADRBITS)-1];

  // Write port and registered read port share one address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory controller that inserts WAITS wait states before each RAM or
// memory-mapped I/O access and signals completion with a one-cycle ready.
module mem_wait_ctrl
  import mem_wait_ctrl_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               ADRBITS = DEF_ADRBITS,
  parameter int               WAITS   = DEF_WAITS,
  parameter logic [WIDTH-1:0] IOADR   = {WIDTH{DEF_IOADR_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             ready,
  output logic             busy,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAITS);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               accept;
  logic               xfer;
  logic [WIDTH-1:0]   adr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               wr_q;
  logic               is_io;

  logic               ram_we;
  logic [ADRBITS-1:0] ram_addr;
  logic [WIDTH-1:0]   ram_rdata;
  logic [WIDTH-1:0]   io_sync;

  // A request is taken only in IDLE and only once ready has dropped,
  // which forces one idle cycle between back-to-back accesses.
  assign accept = (state == ST_IDLE) && !ready && (memread || memwrite);

  // The transfer edge; a reset on that same edge cancels the access.
  assign xfer  = (state == ST_XFER) && !reset;
  assign is_io = (adr_q == IOADR);

  // While idle the RAM looks at the live address so that, with zero wait
  // states, the word is already registered when XFER is reached.
  assign ram_addr = (state == ST_IDLE) ? adr[ADRBITS-1:0] : adr_q[ADRBITS-1:0];
  assign ram_we   = xfer && wr_q && !is_io;

  // FSM state register and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAITS == 0) begin
            state_nxt = ST_XFER;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_XFER;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_XFER: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy = (state == ST_WAIT) || (state == ST_XFER);
  end

  // Completion pulse, registered out of XFER
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= (state == ST_XFER);
    end
  end

  // Capture the request at acceptance; later bus changes are ignored
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      adr_q   <= adr;
      wdata_q <= writedata;
      wr_q    <= memwrite;
    end
  end

  // I/O synchroniser, I/O output port and read-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      io_sync <= '0;
      io_out  <= '0;
      memdata <= '0;
    end else begin
      io_sync <= io_in;
      if (xfer && wr_q && is_io) begin
        io_out <= wdata_q;
      end
      if (xfer && !wr_q) begin
        memdata <= is_io ? io_sync : ram_rdata;
      end
    end
  end

  wait_ram #(
    .WIDTH  (WIDTH),
    .ADRBITS(ADRBITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: three instances (WAITS=1, WAITS=0, and WAITS=3
// with a 16-word RAM) driven by directed steps with a read-data scoreboard.
module tb_mem_wait_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst, rd, wr, rdy, bsy;
  logic [2:0][7:0] adr, wdata, io_in, mdata, io_out;

  int tests = 0;
  int fails = 0;

  int         waits_of [3] = '{1, 0, 3};
  logic [7:0] mask_of  [3] = '{8'hFF, 8'hFF, 8'h0F};
  logic [7:0] mdl [3][256];
  logic [7:0] io_exp [3];
  logic [7:0] sbq [$];

  mem_wait_ctrl #(.WIDTH(8), .ADRBITS(8), .WAITS(1)) u_w1 (
    .clk(clk), .reset(rst[0]), .memread(rd[0]), .memwrite(wr[0]), .adr(adr[0]),
    .writedata(wdata[0]), .memdata(mdata[0]), .ready(rdy[0]), .busy(bsy[0]),
    .io_in(io_in[0]), .io_out(io_out[0]));

  mem_wait_ctrl #(.WIDTH(8), .ADRBITS(8), .WAITS(0)) u_w0 (
    .clk(clk), .reset(rst[1]), .memread(rd[1]), .memwrite(wr[1]), .adr(adr[1]),
    .writedata(wdata[1]), .memdata(mdata[1]), .ready(rdy[1]), .busy(bsy[1]),
    .io_in(io_in[1]), .io_out(io_out[1]));

  mem_wait_ctrl #(.WIDTH(8), .ADRBITS(4), .WAITS(3)) u_w3 (
    .clk(clk), .reset(rst[2]), .memread(rd[2]), .memwrite(wr[2]), .adr(adr[2]),
    .writedata(wdata[2]), .memdata(mdata[2]), .ready(rdy[2]), .busy(bsy[2]),
    .io_in(io_in[2]), .io_out(io_out[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access on instance u; checks latency, busy length, and
  // the read data (from the scoreboard) or the I/O output after a write.
  task automatic access(input int u, input logic w, input logic r,
                        input logic [7:0] a, input logic [7:0] d, input logic hold);
    int n, nb;
    logic seen, is_rd;
    is_rd = r && !w;
    if (is_rd) sbq.push_back((a == 8'hFF) ? io_in[u] : mdl[u][a & mask_of[u]]);
    if (w) begin
      if (a == 8'hFF) io_exp[u] = d;
      else mdl[u][a & mask_of[u]] = d;
    end
    wr[u] = w; rd[u] = r; adr[u] = a; wdata[u] = d;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy[u]) seen = 1'b1;
      else if (bsy[u]) nb++;
    end
    chk($sformatf("latency u%0d a%0h", u, a), 32'(n), 32'(waits_of[u] + 2));
    chk($sformatf("busy_cycles u%0d a%0h", u, a), 32'(nb), 32'(waits_of[u] + 1));
    if (is_rd) begin
      if (sbq.size() > 0) chk($sformatf("read_data u%0d a%0h", u, a), 32'(mdata[u]), 32'(sbq.pop_front()));
      else chk("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      chk($sformatf("io_out u%0d a%0h", u, a), 32'(io_out[u]), 32'(io_exp[u]));
    end
    if (!hold) begin
      wr[u] = 1'b0; rd[u] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic seen;
    rst = '1; rd = '0; wr = '0; adr = '0; wdata = '0;
    io_in = {3{8'h3C}};
    for (int i = 0; i < 3; i++) io_exp[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset_memdata u%0d", u), 32'(mdata[u]), 32'h0);
      chk($sformatf("reset_io_out u%0d", u), 32'(io_out[u]), 32'h0);
      chk($sformatf("reset_ready_busy u%0d", u), 32'({rdy[u], bsy[u]}), 32'h0);
    end
    rst = '0;
    @(posedge clk); #1;

    // WAITS=1: RAM write/read, I/O write/read, write priority
    access(0, 1'b1, 1'b0, 8'h10, 8'h5A, 1'b0);
    access(0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0);
    access(0, 1'b1, 1'b0, 8'h20, 8'h12, 1'b0);
    access(0, 1'b1, 1'b0, 8'hFF, 8'hC3, 1'b0);
    access(0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    access(0, 1'b1, 1'b1, 8'h04, 8'h11, 1'b0);
    access(0, 1'b0, 1'b1, 8'h04, 8'h00, 1'b0);

    // Reset while in WAIT aborts a write of 0x77 to 0x20
    wr[0] = 1'b1; adr[0] = 8'h20; wdata[0] = 8'h77;
    @(posedge clk); #1;
    chk("abort_busy_before_reset", 32'(bsy[0]), 32'h1);
    wr[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    io_exp[0] = 8'h00;
    chk("abort_outputs_zero", 32'({rdy[0], bsy[0], mdata[0], io_out[0]}), 32'h0);
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy[0]) n++;
    end
    chk("abort_no_ready", 32'(n), 32'h0);
    access(0, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0);

    // Request held through ready is not re-accepted in the ready cycle
    access(0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1);
    chk("hold_not_reaccepted", 32'(bsy[0]), 32'h0);
    sbq.push_back(mdl[0][8'h10]);
    @(posedge clk); #1;
    chk("hold_accepted_next", 32'(bsy[0]), 32'h1);
    rd[0] = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy[0]) seen = 1'b1;
    end
    chk("hold_second_latency", 32'(n), 32'h2);
    if (sbq.size() > 0) chk("hold_second_data", 32'(mdata[0]), 32'(sbq.pop_front()));
    @(posedge clk); #1;

    // WAITS=0
    access(1, 1'b1, 1'b0, 8'h33, 8'hA7, 1'b0);
    access(1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);

    // WAITS=3 with 16-word RAM: I/O write leaves aliased RAM word intact
    access(2, 1'b1, 1'b0, 8'h0F, 8'hA5, 1'b0);
    access(2, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    access(2, 1'b1, 1'b0, 8'hFF, 8'hC3, 1'b0);
    access(2, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    access(2, 1'b0, 1'b1, 8'h1F, 8'h00, 1'b0);
    access(2, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
